xor_share_arbiter: RTL and testbench

- Shares one N-bit bitwise-XOR datapath (an xorN instance) among M requesters using round-robin arbitration and per-requester valid/ready handshakes.
- Each accepted operand pair (A, B) produces one registered result, tagged with the requester index, on a single valid/ready result port.
- Sits between the operand sources and the downstream consumer that collects XOR results.

---
 rtl/xor_share_arbiter_if.sv | 34 +++
 rtl/xor_share_arbiter.sv | 157 +++++++++++++++
 tb/tb_xor_share_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/xor_share_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : xor_share_arbiter_if
//  Description : Requester and result handshake bundle for xor_share_arbiter.
//                master = operand sources / result consumer side,
//                slave  = arbiter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface xor_share_arbiter_if #(
    parameter int N = 8,
    parameter int M = 4
);
    localparam int IDW = (M > 1) ? $clog2(M) : 1;

    logic [M-1:0]   req_valid;
    logic [M-1:0]   req_ready;
    logic [M*N-1:0] req_a;
    logic [M*N-1:0] req_b;
    logic           res_valid;
    logic           res_ready;
    logic [N-1:0]   res_data;
    logic [IDW-1:0] res_id;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id
    );
endinterface
`default_nettype wire

// File: rtl/xor_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : xor_share_arbiter (with helper xorN)
//  Description : Round-robin sharing of one N-bit XOR datapath among M
//                requesters. One registered, id-tagged result per accept;
//                full throughput when the consumer is ready.
//                Optional macro XOR_SHARE_ARB_STATS_EN adds a 16-bit
//                saturating accepted-operation counter on port op_count.
//  Revision    : 1.0 - initial release
// ============================================================================

// Plain N-bit bitwise XOR datapath.
module xorN #(
    parameter int N = 8
) (
    input  wire logic [N-1:0] i_a,
    input  wire logic [N-1:0] i_b,
    output logic      [N-1:0] o_y
);
    assign o_y = i_a ^ i_b;
endmodule

module xor_share_arbiter #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    xor_share_arbiter_if.slave     bus
`ifdef XOR_SHARE_ARB_STATS_EN
    ,
    output logic [15:0]            op_count
`endif
);
    localparam int IDW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_res_data;
    logic [IDW-1:0] r_res_id;
    logic [IDW-1:0] r_last_grant;

    logic [N-1:0]   w_a [M];
    logic [N-1:0]   w_b [M];
    logic [IDW:0]   w_sum [M];
    logic [IDW-1:0] w_cand [M];
    logic [IDW-1:0] w_gidx;
    logic           w_found;
    logic           w_can_accept;
    logic           w_accept;
    logic [M-1:0]   w_ready;
    logic [N-1:0]   w_sel_a;
    logic [N-1:0]   w_sel_b;
    logic [N-1:0]   w_xor;

    // Split the flat operand buses into per-requester words, and list the
    // requester indices in priority order starting just after last_grant.
    // The sum is one bit wider than an index so the modulo-M wrap is exact.
    generate
        for (genvar i = 0; i < M; i++) begin : g_unpack
            assign w_a[i]    = bus.req_a[i*N +: N];
            assign w_b[i]    = bus.req_b[i*N +: N];
            assign w_sum[i]  = {1'b0, r_last_grant} + (IDW+1)'(i + 1);
            assign w_cand[i] = (w_sum[i] >= (IDW+1)'(M))
                             ? IDW'(w_sum[i] - (IDW+1)'(M))
                             : w_sum[i][IDW-1:0];
        end
    endgenerate

    // Priority pick: scan from lowest priority up so the highest-priority
    // valid candidate is the last one written.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = M - 1; k >= 0; k--) begin
            if (bus.req_valid[w_cand[k]]) begin
                w_found = 1'b1;
                w_gidx  = w_cand[k];
            end
        end
    end

    assign w_can_accept = (r_state == ST_EMPTY) || bus.res_ready;
    assign w_accept     = w_found && w_can_accept;

    // One-hot ready toward the granted requester only.
    always_comb begin
        w_ready         = '0;
        w_ready[w_gidx] = w_accept;
    end

    assign w_sel_a = w_a[w_gidx];
    assign w_sel_b = w_b[w_gidx];

    xorN #(
        .N (N)
    ) u_xor (
        .i_a (w_sel_a),
        .i_b (w_sel_b),
        .o_y (w_xor)
    );

    // Result register state machine: load on accept, empty on drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_res_data   <= '0;
            r_res_id     <= '0;
            r_last_grant <= IDW'(M - 1);
        end else begin
            if (w_accept) begin
                r_res_data   <= w_xor;
                r_res_id     <= w_gidx;
                r_last_grant <= w_gidx;
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (!w_accept && bus.res_ready) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.res_valid = (r_state == ST_FULL);
    assign bus.res_data  = r_res_data;
    assign bus.res_id    = r_res_id;

`ifdef XOR_SHARE_ARB_STATS_EN
    logic [15:0] r_op_count;

    // Saturating count of accepted operations.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_accept && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xor_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xor_share_arbiter
//  Description : Self-checking bench for xor_share_arbiter: directed scenarios
//                plus randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_share_arbiter;
    localparam int N   = 8;
    localparam int M   = 4;
    localparam int IDW = 2;

    logic clk;
    logic rst_n;

    xor_share_arbiter_if #(.N(N), .M(M)) bus ();

`ifdef XOR_SHARE_ARB_STATS_EN
    logic [15:0] op_count;
`endif

    xor_share_arbiter #(.N(N), .M(M)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave)
`ifdef XOR_SHARE_ARB_STATS_EN
        ,
        .op_count (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driven operand words and staged next-cycle values
    logic [N-1:0] tb_a [M];
    logic [N-1:0] tb_b [M];
    logic [N-1:0] nx_a [M];
    logic [N-1:0] nx_b [M];
    logic [M-1:0] tb_v;

    generate
        for (genvar i = 0; i < M; i++) begin : g_drive
            assign bus.req_a[i*N +: N] = tb_a[i];
            assign bus.req_b[i*N +: N] = tb_b[i];
        end
    endgenerate
    assign bus.req_valid = tb_v;

    // Behavioural model state
    logic         m_valid;
    logic [N-1:0] m_data;
    int           m_id;
    int           m_last;
    int           m_cnt;
    int           last_g;

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs after the edge, check outputs mid-cycle
    // against the model, then advance the model across the coming edge.
    task automatic step(input logic [M-1:0] v, input logic rr, input logic rn);
        logic           can;
        int             g;
        int             er;
        int             idx;
        logic [IDW-1:0] gi;
        @(posedge clk);
        #1;
        for (int i = 0; i < M; i++) begin
            tb_a[i] = nx_a[i];
            tb_b[i] = nx_b[i];
        end
        tb_v          = v;
        bus.res_ready = rr;
        rst_n         = rn;
        #3;
        can = !m_valid || rr;
        g   = -1;
        for (int k = 1; k <= M; k++) begin
            idx = (m_last + k) % M;
            if (g < 0 && ((32'(v) >> idx) & 1) == 1) g = idx;
        end
        er = (can && g >= 0) ? (1 << g) : 0;
        check("req_ready", 32'(bus.req_ready), er);
        check("res_valid", 32'(bus.res_valid), 32'(m_valid));
        check("res_data",  32'(bus.res_data),  32'(m_data));
        check("res_id",    32'(bus.res_id),    m_id);
`ifdef XOR_SHARE_ARB_STATS_EN
        check("op_count",  32'(op_count),      m_cnt);
`endif
        last_g = -1;
        if (!rn) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_id    = 0;
            m_last  = M - 1;
            m_cnt   = 0;
        end else if (er != 0) begin
            gi      = IDW'(g);
            m_valid = 1'b1;
            m_data  = nx_a[gi] ^ nx_b[gi];
            m_id    = g;
            m_last  = g;
            if (m_cnt < 65535) m_cnt++;
            last_g  = g;
        end else if (rr) begin
            m_valid = 1'b0;
        end
    endtask

    int             gq[$];
    int             exp_order[5];
    logic [M-1:0]   rv;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.res_ready = 1'b0;
        tb_v    = '0;
        for (int i = 0; i < M; i++) begin
            tb_a[i] = '0; tb_b[i] = '0; nx_a[i] = '0; nx_b[i] = '0;
        end
        m_valid = 1'b0; m_data = '0; m_id = 0; m_last = M - 1; m_cnt = 0;
        last_g  = -1;

        // Reset, then a single request from requester 2
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b1);
        nx_a[2] = 8'hF0; nx_b[2] = 8'h3C;
        step(4'b0100, 1'b1, 1'b1);
        check("t1_grant", 32'(last_g), 2);
        step(4'b0000, 1'b1, 1'b1);
        check("t1_data", 32'(bus.res_data), 32'h00CC);
        check("t1_id",   32'(bus.res_id),   2);

        // All requesters continuously valid: strict rotation from 0
        step(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < M; i++) begin
            nx_a[i] = N'(i); nx_b[i] = 8'hFF;
        end
        exp_order = '{0, 1, 2, 3, 0};
        gq.delete();
        for (int c = 0; c < 5; c++) begin
            step(4'b1111, 1'b1, 1'b1);
            gq.push_back(last_g);
        end
        for (int c = 0; c < 5; c++) check("t2_order", 32'(gq[c]), 32'(exp_order[c]));

        // Back-pressure with requesters 1 and 3 waiting
        nx_a[1] = 8'h5A; nx_b[1] = 8'h0F;
        nx_a[3] = 8'h33; nx_b[3] = 8'h11;
        for (int c = 0; c < 3; c++) step(4'b1010, 1'b0, 1'b1);
        check("t3_held", 32'(bus.res_data), 32'h00FF);
        step(4'b1010, 1'b1, 1'b1);
        check("t3_first", 32'(last_g), 1);
        step(4'b1000, 1'b1, 1'b1);
        check("t3_second", 32'(last_g), 3);

        // Wrap-around, then 1 before 0
        nx_a[0] = 8'hA5; nx_b[0] = 8'hFF;
        step(4'b0001, 1'b1, 1'b1);
        check("t4_wrap", 32'(last_g), 0);
        nx_a[1] = 8'h81;
        step(4'b0011, 1'b1, 1'b1);
        check("t4_rr1", 32'(last_g), 1);
        step(4'b0001, 1'b1, 1'b1);
        check("t4_rr0", 32'(last_g), 0);

        // Reset while a result is pending and requesters are valid
        step(4'b1111, 1'b0, 1'b0);
        step(4'b0110, 1'b1, 1'b1);
        check("t5_grant", 32'(last_g), 1);

        // Randomized traffic honouring the hold-until-accepted rule
        rv = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < M; i++) begin
                if (!(rv[i] && last_g != i && $urandom_range(0, 9) != 0)) begin
                    rv[i]   = ($urandom_range(0, 1) == 1);
                    nx_a[i] = N'($urandom);
                    nx_b[i] = N'($urandom);
                end
            end
            step(rv, ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) != 0));
        end

`ifdef XOR_SHARE_ARB_STATS_EN
        // Counter: five accepts, then run past saturation
        step(4'b0000, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) step(4'b1111, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b1);
        check("cnt_5", 32'(op_count), 5);
        for (int c = 0; c < 65540; c++) step(4'b1111, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b1);
        check("cnt_sat", 32'(op_count), 32'h0000FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
